// File: rtl/bf_program_loader.sv
// Brainfuck source loader: ASCII stream to opcodes in BCD-addressed memory.
// Optional LOADER_BRACKET_CHECK_EN enables bracket-depth checking.
module bf_program_loader #(
  parameter int AddrWidth  = 12,
  parameter int DataWidth  = 4,
  parameter int DepthWidth = 8
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic                 Start,
  input  logic [7:0]           In_data,
  input  logic                 In_valid,
  input  logic                 In_last,
  output logic                 In_ready,
  output logic                 Wr_en,
  output logic [AddrWidth-1:0] Wr_addr,
  output logic [DataWidth-1:0] Wr_data,
  output logic                 Busy,
  output logic                 Done,
  output logic                 Error,
  output logic [AddrWidth-1:0] Length
);

  localparam int Digits = AddrWidth / 4;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_FINISH, S_DONE, S_ERROR
  } state_t;

  function automatic logic [AddrWidth-1:0] bcd_inc(
    input logic [AddrWidth-1:0] a
  );
    logic c;
    bcd_inc = a;
    c = 1'b1;
    for (int i = 0; i < Digits; i++) begin
      if (c) begin
        if (a[4*i +: 4] == 4'd9) begin
          bcd_inc[4*i +: 4] = 4'd0;
        end else begin
          bcd_inc[4*i +: 4] = a[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
  endfunction

  function automatic logic [AddrWidth-1:0] bcd_all9();
    bcd_all9 = '0;
    for (int i = 0; i < Digits; i++) bcd_all9[4*i +: 4] = 4'd9;
  endfunction

  // Top address is kept free so HALT always has a slot.
  localparam logic [AddrWidth-1:0] AddrLast = bcd_all9();

  state_t               r_state, w_state;
  logic [AddrWidth-1:0] r_addr, w_addr;
  logic                 r_wr_en, w_wr_en;
  logic [AddrWidth-1:0] r_wr_addr, w_wr_addr;
  logic [DataWidth-1:0] r_wr_data, w_wr_data;
  logic [AddrWidth-1:0] r_len, w_len;
  logic                 r_halt, w_halt;
  logic [DataWidth-1:0] w_op;
  logic                 w_op_ok;
  logic                 w_hs;
  logic                 w_err;

`ifdef LOADER_BRACKET_CHECK_EN
  logic [DepthWidth-1:0] r_depth, w_depth;
`else
  if (DepthWidth < 1) begin : g_no_depth
  end
`endif

  assign In_ready = (r_state == S_LOAD);
  assign Busy     = (r_state == S_LOAD) || (r_state == S_FINISH);
  assign Done     = (r_state == S_DONE);
  assign Error    = (r_state == S_ERROR);
  assign Wr_en    = r_wr_en;
  assign Wr_addr  = r_wr_addr;
  assign Wr_data  = r_wr_data;
  assign Length   = r_len;

  assign w_hs = In_valid && (r_state == S_LOAD) && !Start;

  always_comb begin
    w_op    = '0;
    w_op_ok = 1'b1;
    unique case (In_data)
      8'h2B:   w_op = DataWidth'(2);
      8'h2D:   w_op = DataWidth'(3);
      8'h3E:   w_op = DataWidth'(4);
      8'h3C:   w_op = DataWidth'(5);
      8'h5B:   w_op = DataWidth'(6);
      8'h5D:   w_op = DataWidth'(7);
      8'h2E:   w_op = DataWidth'(8);
      8'h2C:   w_op = DataWidth'(9);
      default: w_op_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_state   = r_state;
    w_addr    = r_addr;
    w_wr_en   = 1'b0;
    w_wr_addr = r_wr_addr;
    w_wr_data = r_wr_data;
    w_len     = r_len;
    w_halt    = r_halt;
    w_err     = 1'b0;
`ifdef LOADER_BRACKET_CHECK_EN
    w_depth   = r_depth;
`endif
    if (Start) begin
      w_state = S_LOAD;
      w_addr  = '0;
      w_len   = '0;
      w_halt  = 1'b0;
`ifdef LOADER_BRACKET_CHECK_EN
      w_depth = '0;
`endif
    end else begin
      unique case (r_state)
        S_LOAD: begin
          if (w_hs) begin
            if (w_op_ok) begin
              if (r_addr == AddrLast) w_err = 1'b1;
`ifdef LOADER_BRACKET_CHECK_EN
              if (In_data == 8'h5D && r_depth == '0) w_err = 1'b1;
              if (In_data == 8'h5B && &r_depth) w_err = 1'b1;
`endif
              if (!w_err) begin
                w_wr_en   = 1'b1;
                w_wr_addr = r_addr;
                w_wr_data = w_op;
                w_addr    = bcd_inc(r_addr);
`ifdef LOADER_BRACKET_CHECK_EN
                if (In_data == 8'h5B) w_depth = r_depth + 1'b1;
                if (In_data == 8'h5D) w_depth = r_depth - 1'b1;
`endif
              end
            end
            if (w_err) begin
              w_state = S_ERROR;
            end else if (In_last) begin
              w_state = S_FINISH;
              w_halt  = 1'b0;
            end
          end
        end
        // Two cycles here so the HALT strobe lands while still Busy.
        S_FINISH: begin
          if (r_halt) begin
            w_state = S_DONE;
            w_len   = bcd_inc(r_addr);
`ifdef LOADER_BRACKET_CHECK_EN
          end else if (r_depth != '0) begin
            w_state = S_ERROR;
`endif
          end else begin
            w_wr_en   = 1'b1;
            w_wr_addr = r_addr;
            w_wr_data = DataWidth'(1);
            w_halt    = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_len     <= '0;
      r_halt    <= 1'b0;
`ifdef LOADER_BRACKET_CHECK_EN
      r_depth   <= '0;
`endif
    end else begin
      r_state   <= w_state;
      r_addr    <= w_addr;
      r_wr_en   <= w_wr_en;
      r_wr_addr <= w_wr_addr;
      r_wr_data <= w_wr_data;
      r_len     <= w_len;
      r_halt    <= w_halt;
`ifdef LOADER_BRACKET_CHECK_EN
      r_depth   <= w_depth;
`endif
    end
  end

endmodule

// File: tb/tb_bf_program_loader.sv
// Scoreboard bench for bf_program_loader: expected writes queued at drive
// time, popped by a monitor on each Wr_en strobe.
module tb_bf_program_loader;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        Start = 1'b0;
  logic [7:0]  In_data = 8'h00;
  logic        In_valid = 1'b0;
  logic        In_last = 1'b0;
  logic        In_ready;
  logic        Wr_en;
  logic [11:0] Wr_addr;
  logic [3:0]  Wr_data;
  logic        Busy;
  logic        Done;
  logic        Error;
  logic [11:0] Length;

  int checks = 0;
  int passes = 0;
  int m_addr = 0;
  logic [15:0] sb[$];

  bf_program_loader dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start),
    .In_data(In_data), .In_valid(In_valid), .In_last(In_last),
    .In_ready(In_ready), .Wr_en(Wr_en), .Wr_addr(Wr_addr),
    .Wr_data(Wr_data), .Busy(Busy), .Done(Done), .Error(Error),
    .Length(Length)
  );

  always #5 Clk = ~Clk;

  function automatic logic [11:0] to_bcd(input int n);
    return {4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
  endfunction

  function automatic logic [3:0] enc(input logic [7:0] c);
    case (c)
      "+":     return 4'd2;
      "-":     return 4'd3;
      ">":     return 4'd4;
      "<":     return 4'd5;
      "[":     return 4'd6;
      "]":     return 4'd7;
      ".":     return 4'd8;
      ",":     return 4'd9;
      default: return 4'd0;
    endcase
  endfunction

  always @(negedge Clk) begin
    if (Rst_n && Wr_en) begin
      logic [15:0] e;
      checks++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_write got addr=%h data=%0d want none",
                 Wr_addr, Wr_data);
      end else begin
        e = sb.pop_front();
        if ({Wr_addr, Wr_data} !== e)
          $display("FAIL write got addr=%h data=%0d want addr=%h data=%0d",
                   Wr_addr, Wr_data, e[15:4], e[3:0]);
        else passes++;
      end
    end
  end

  task automatic do_start();
    @(negedge Clk);
    Start = 1'b1;
    @(posedge Clk);
    #1 Start = 1'b0;
    m_addr = 0;
  endtask

  task automatic send(input logic [7:0] c, input bit last, input bit push);
    int n;
    n = 0;
    @(negedge Clk);
    In_data = c; In_valid = 1'b1; In_last = last;
    while (!In_ready && n < 20) begin
      @(negedge Clk);
      n++;
    end
    if (!In_ready) begin
      checks++;
      $display("FAIL send_timeout got In_ready=0 want 1");
    end
    if (push && enc(c) != 4'd0) begin
      sb.push_back({to_bcd(m_addr), enc(c)});
      m_addr++;
    end
    @(posedge Clk);
    #1 In_valid = 1'b0; In_last = 1'b0;
  endtask

  task automatic push_halt();
    sb.push_back({to_bcd(m_addr), 4'd1});
  endtask

  task automatic wait_end(input string nm, input bit exp_done,
                          input logic [11:0] exp_len);
    int n;
    n = 0;
    @(negedge Clk);
    while (!Done && !Error && n < 50) begin
      @(negedge Clk);
      n++;
    end
    checks++;
    if (Done !== exp_done || Error !== !exp_done)
      $display("FAIL %s_status got done=%b err=%b want done=%b err=%b",
               nm, Done, Error, exp_done, !exp_done);
    else passes++;
    if (exp_done) begin
      checks++;
      if (Length !== exp_len)
        $display("FAIL %s_length got %h want %h", nm, Length, exp_len);
      else passes++;
    end
    checks++;
    if (sb.size() != 0)
      $display("FAIL %s_pending got %0d writes left want 0", nm, sb.size());
    else passes++;
    sb.delete();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge Clk);
    checks++;
    if ({In_ready, Wr_en, Busy, Done, Error} !== 5'b0)
      $display("FAIL reset_flags got %b want 00000",
               {In_ready, Wr_en, Busy, Done, Error});
    else passes++;
    checks++;
    if ({Wr_addr, Wr_data, Length} !== 28'h0)
      $display("FAIL reset_buses got %h want 0", {Wr_addr, Wr_data, Length});
    else passes++;
    Rst_n = 1'b1;
    @(negedge Clk);
    checks++;
    if ({In_ready, Busy, Done, Error} !== 4'b0)
      $display("FAIL idle_flags got %b want 0000",
               {In_ready, Busy, Done, Error});
    else passes++;
  endtask

  task automatic test_basic();
    string s;
    s = "++[>+<-]";
    do_start();
    for (int i = 0; i < s.len(); i++) send(s[i], i == s.len() - 1, 1'b1);
    push_halt();
    wait_end("basic", 1'b1, 12'h009);
  endtask

  task automatic test_bcd();
    do_start();
    for (int i = 0; i < 12; i++) send("+", i == 11, 1'b1);
    push_halt();
    wait_end("bcd", 1'b1, 12'h013);
  endtask

  task automatic test_drop();
    do_start();
    send("+", 1'b0, 1'b1);
    send("a", 1'b0, 1'b1);
    send(8'h0A, 1'b0, 1'b1);
    send("-", 1'b1, 1'b1);
    push_halt();
    wait_end("drop", 1'b1, 12'h003);
  endtask

  task automatic test_bracket();
    do_start();
`ifdef LOADER_BRACKET_CHECK_EN
    send("]", 1'b1, 1'b0);
    wait_end("bracket", 1'b0, 12'h000);
`else
    send("]", 1'b1, 1'b1);
    push_halt();
    wait_end("bracket", 1'b1, 12'h002);
`endif
  endtask

  task automatic test_full();
    do_start();
    for (int i = 0; i < 999; i++) send("+", 1'b0, 1'b1);
    repeat (2) @(negedge Clk);
    checks++;
    if (Busy !== 1'b1 || Error !== 1'b0 || sb.size() != 0)
      $display("FAIL full_999 got busy=%b err=%b left=%0d want 1 0 0",
               Busy, Error, sb.size());
    else passes++;
    send("+", 1'b0, 1'b0);
    @(negedge Clk);
    checks++;
    if (Error !== 1'b1 || Busy !== 1'b0)
      $display("FAIL full_err got err=%b busy=%b want 1 0", Error, Busy);
    else passes++;
    sb.delete();
  endtask

  task automatic test_restart();
    do_start();
    for (int i = 0; i < 5; i++) send("+", 1'b0, 1'b1);
    @(negedge Clk);
    Start = 1'b1; In_valid = 1'b1; In_data = "."; In_last = 1'b1;
    @(posedge Clk);
    #1 Start = 1'b0; In_valid = 1'b0; In_last = 1'b0;
    m_addr = 0;
    send("-", 1'b1, 1'b1);
    push_halt();
    wait_end("restart", 1'b1, 12'h002);
  endtask

  task automatic test_reset_mid();
    do_start();
    @(negedge Clk);
    In_valid = 1'b1; In_data = ">";
    @(posedge Clk);
    #1 In_valid = 1'b0;
    checks++;
    if (Wr_en !== 1'b1 || Wr_data !== 4'd4)
      $display("FAIL mid_write got en=%b data=%0d want 1 4", Wr_en, Wr_data);
    else passes++;
    Rst_n = 1'b0;
    #1;
    checks++;
    if ({Wr_en, Busy, In_ready, Wr_data} !== 7'b0)
      $display("FAIL mid_reset got %b want 0000000",
               {Wr_en, Busy, In_ready, Wr_data});
    else passes++;
    @(negedge Clk);
    Rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bcd();
    test_drop();
    test_bracket();
    test_restart();
    test_full();
    test_reset_mid();
    repeat (3) @(negedge Clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
